// File: rtl/if_pc_sequencer.sv
// if_pc_sequencer: instruction-fetch address generator with redirect checks, window wrap/fault and accept counter
module if_pc_sequencer #(
  parameter int XLEN = 32,
  parameter int IF_INC = 4,
  parameter logic [XLEN-1:0] IF_BASE_ADDR = 32'h1000_0000,
  parameter logic [XLEN-1:0] IF_MAX_ADDR = 32'h1000_3FFF,
  parameter int WRAP_EN = 0,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            req_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            fault_clear,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [XLEN-1:0] fault_addr,
  output logic [CNT_W-1:0] fetch_cnt
);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;
  localparam logic [XLEN-1:0] L_INC = XLEN'(IF_INC);
  localparam logic [XLEN-1:0] L_MASK = L_INC - 1'b1;
  state_t r_state, w_state_nx;
  logic r_pend, w_pend_nx;
  logic [XLEN-1:0] r_addr, w_addr_nx, r_faddr, w_faddr_nx;
  logic [1:0] r_cause, w_cause_nx;
  logic [CNT_W-1:0] r_cnt;
  logic w_accept, w_rd_mis, w_rd_oor, w_rd_bad, w_ovr;
  logic [1:0] w_rd_cause;
  logic [XLEN-1:0] w_seq;
  logic [XLEN:0] w_rd_end, w_seq_end;
  assign req_valid = (r_state == S_RUN) & (r_pend | ~stall);
  assign req_addr = r_addr;
  assign fault = (r_state == S_FAULT);
  assign fault_cause = r_cause;
  assign fault_addr = r_faddr;
  assign fetch_cnt = r_cnt;
  assign w_accept = req_valid & req_ready;
  // Range arithmetic is one bit wider so a carry-out reads as past the window.
  assign w_rd_mis = |(redirect_addr & L_MASK);
  assign w_rd_end = {1'b0, redirect_addr} + {1'b0, L_MASK};
  assign w_rd_oor = (redirect_addr < IF_BASE_ADDR) | (w_rd_end > {1'b0, IF_MAX_ADDR});
  assign w_rd_bad = w_rd_mis | w_rd_oor;
  assign w_rd_cause = w_rd_mis ? 2'b01 : 2'b10;
  assign w_seq = r_addr + L_INC;
  assign w_seq_end = {1'b0, r_addr} + {1'b0, L_INC} + {1'b0, L_MASK};
  assign w_ovr = w_seq_end > {1'b0, IF_MAX_ADDR};
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx = r_addr;
    w_cause_nx = r_cause;
    w_faddr_nx = r_faddr;
    case (r_state)
      S_BOOT: begin
        w_state_nx = (redirect_valid & w_rd_bad) ? S_FAULT : S_RUN;
        w_addr_nx = (redirect_valid & ~w_rd_bad) ? redirect_addr : IF_BASE_ADDR;
        w_cause_nx = (redirect_valid & w_rd_bad) ? w_rd_cause : r_cause;
        w_faddr_nx = (redirect_valid & w_rd_bad) ? redirect_addr : r_faddr;
      end
      S_RUN: begin
        if (redirect_valid) begin
          w_state_nx = w_rd_bad ? S_FAULT : S_RUN;
          w_addr_nx = w_rd_bad ? r_addr : redirect_addr;
          w_cause_nx = w_rd_bad ? w_rd_cause : r_cause;
          w_faddr_nx = w_rd_bad ? redirect_addr : r_faddr;
        end else if (w_accept) begin
          w_state_nx = (w_ovr && WRAP_EN == 0) ? S_FAULT : S_RUN;
          w_addr_nx = w_ovr ? (WRAP_EN != 0 ? IF_BASE_ADDR : r_addr) : w_seq;
          w_cause_nx = (w_ovr && WRAP_EN == 0) ? 2'b11 : r_cause;
          w_faddr_nx = (w_ovr && WRAP_EN == 0) ? w_seq : r_faddr;
        end
      end
      default: begin
        if (redirect_valid) begin
          w_state_nx = w_rd_bad ? S_FAULT : S_RUN;
          w_addr_nx = w_rd_bad ? r_addr : redirect_addr;
          w_cause_nx = w_rd_bad ? w_rd_cause : 2'b00;
          w_faddr_nx = w_rd_bad ? redirect_addr : '0;
        end else if (fault_clear) begin
          w_state_nx = S_RUN;
          w_addr_nx = IF_BASE_ADDR;
          w_cause_nx = 2'b00;
          w_faddr_nx = '0;
        end
      end
    endcase
  end
  // A request stays pinned only while it was shown, not taken, and not redirected away.
  assign w_pend_nx = (r_state == S_RUN) & req_valid & ~req_ready & ~redirect_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pend <= 1'b0;
      r_addr <= IF_BASE_ADDR;
      r_cause <= 2'b00;
      r_faddr <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pend <= w_pend_nx;
      r_addr <= w_addr_nx;
      r_cause <= w_cause_nx;
      r_faddr <= w_faddr_nx;
      if (w_accept && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_if_pc_sequencer.sv
// tb_if_pc_sequencer: directed checks of fetch sequencing, stall/pending, redirects, faults, wrap and reset
module tb_if_pc_sequencer;
  logic clk = 1'b0;
  logic rst, stall, req_ready, redirect_valid, fault_clear;
  logic [31:0] redirect_addr;
  logic v0, f0, v1, f1;
  logic [31:0] a0, fa0, n0, a1, fa1;
  logic [1:0] c0, c1, n1;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [31:0] BASE = 32'h1000_0000;
  if_pc_sequencer #(.WRAP_EN(0)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .req_valid(v0), .req_addr(a0), .req_ready(req_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .fault_clear(fault_clear),
    .fault(f0), .fault_cause(c0), .fault_addr(fa0), .fetch_cnt(n0)
  );
  if_pc_sequencer #(.WRAP_EN(1), .CNT_W(2)) u_wrp (
    .clk(clk), .rst(rst), .stall(stall), .req_valid(v1), .req_addr(a1), .req_ready(req_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .fault_clear(fault_clear),
    .fault(f1), .fault_cause(c1), .fault_addr(fa1), .fetch_cnt(n1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; stall = 1'b0; req_ready = 1'b1; redirect_valid = 1'b0; fault_clear = 1'b0;
    redirect_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", v0, 0); chk("rst_addr", a0, BASE); chk("rst_fault", f0, 0);
    chk("rst_cause", c0, 0); chk("rst_faddr", fa0, 0); chk("rst_cnt", n0, 0);
    rst = 1'b0;
    chk("boot_valid", v0, 0);
    step(); chk("run0_valid", v0, 1); chk("run0_addr", a0, BASE);
    step(); chk("run1_addr", a0, BASE + 4);
    step(); chk("run2_addr", a0, BASE + 8);
    step(); chk("run3_addr", a0, BASE + 12); chk("cnt3", n0, 3);
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = BASE + 4;
    step(); redirect_valid = 1'b0;
    chk("pend_valid0", v0, 1); chk("pend_addr0", a0, BASE + 4); chk("pend_cnt", n0, 3);
    step(); stall = 1'b1; chk("pend_valid1", v0, 1); chk("pend_addr1", a0, BASE + 4);
    step(); stall = 1'b0; chk("pend_valid2", v0, 1); chk("pend_addr2", a0, BASE + 4);
    step(); stall = 1'b1; chk("pend_valid3", v0, 1); chk("pend_addr3", a0, BASE + 4);
    req_ready = 1'b1;
    step(); chk("adv_addr", a0, BASE + 8); chk("adv_cnt", n0, 4); chk("stall_blocks", v0, 0);
    stall = 1'b0; #1 chk("unstall_valid", v0, 1);
    step(); step(); chk("at10_addr", a0, BASE + 32'h10); chk("at10_cnt", n0, 6);
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = BASE + 32'h100;
    #1 chk("at10_valid", v0, 1);
    step(); chk("redir_addr", a0, BASE + 32'h100); chk("redir_cnt", n0, 6);
    redirect_addr = BASE + 32'h102;
    step(); chk("mis_fault", f0, 1); chk("mis_cause", c0, 1); chk("mis_faddr", fa0, BASE + 32'h102);
    chk("mis_valid", v0, 0);
    redirect_addr = 32'h0000_0001;
    step(); chk("prio_cause", c0, 1); chk("prio_faddr", fa0, 32'h0000_0001);
    redirect_addr = 32'h2000_0000; fault_clear = 1'b1;
    step(); chk("oor_fault", f0, 1); chk("oor_cause", c0, 2); chk("oor_faddr", fa0, 32'h2000_0000);
    fault_clear = 1'b0; redirect_addr = BASE + 32'h200;
    step(); chk("exit_fault", f0, 0); chk("exit_addr", a0, BASE + 32'h200);
    chk("exit_cause", c0, 0); chk("exit_faddr", fa0, 0); chk("exit_valid", v0, 1);
    redirect_addr = BASE + 32'h3FFC;
    step(); redirect_valid = 1'b0; chk("end_addr", a0, BASE + 32'h3FFC); chk("end_valid", v0, 1);
    req_ready = 1'b1;
    step(); req_ready = 1'b0;
    chk("ovr_fault", f0, 1); chk("ovr_cause", c0, 3); chk("ovr_faddr", fa0, BASE + 32'h4000);
    chk("ovr_valid", v0, 0); chk("ovr_cnt", n0, 7);
    chk("wrap_addr", a1, BASE); chk("wrap_fault", f1, 0); chk("wrap_valid", v1, 1); chk("sat_cnt", n1, 3);
    fault_clear = 1'b1;
    step(); fault_clear = 1'b0;
    chk("clr_fault", f0, 0); chk("clr_addr", a0, BASE); chk("clr_valid", v0, 1); chk("clr_cause", c0, 0);
    redirect_valid = 1'b1; redirect_addr = BASE + 32'h40;
    step(); redirect_valid = 1'b0; chk("r40_addr", a0, BASE + 32'h40);
    step(); stall = 1'b1; chk("r40_pend", v0, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", v0, 0); chk("arst_addr", a0, BASE); chk("arst_cnt", n0, 0); chk("arst_fault", f0, 0);
    @(posedge clk); #1 rst = 1'b0; stall = 1'b0;
    chk("reboot_valid", v0, 0);
    step(); chk("reboot_run", v0, 1); chk("reboot_addr", a0, BASE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
